// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the secuenciador_pc fetch front end:
// FSM state encoding, pending-redirect kinds, default width and PC step.
package secuenciador_pkg;

    localparam int ANCHO_DEF  = 64;
    localparam int INCREMENTO = 4;

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        BUSCAR   = 2'd1,
        DETENIDO = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        NINGUNO = 2'd0,
        SALTO   = 2'd1,
        EXC     = 2'd2
    } pendiente_t;

endpackage

// File: rtl/secuenciador_pc_if.sv
// Bus between the fetch sequencer, instruction memory and the IF/ID stage.
// master: the sequencer itself. slave: the surrounding pipeline/memory.
interface secuenciador_pc_if
    import secuenciador_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) ();

    logic             salto_tomado;
    logic [ANCHO-1:0] direccion_salto;
    logic             excepcion;
    logic             detener;
    logic             im_ack;
    logic             im_req;
    logic [ANCHO-1:0] direccion_im;
    logic             buscado_valido;
    logic [ANCHO-1:0] pc_buscado;
    logic [ANCHO-1:0] pc_epc;

    modport master (
        input  salto_tomado, direccion_salto, excepcion, detener, im_ack,
        output im_req, direccion_im, buscado_valido, pc_buscado, pc_epc
    );

    modport slave (
        output salto_tomado, direccion_salto, excepcion, detener, im_ack,
        input  im_req, direccion_im, buscado_valido, pc_buscado, pc_epc
    );

endinterface

// File: rtl/secuenciador_pc_registro_pc.sv
// registro_pc: program-counter register with asynchronous active-high reset
// to a configurable vector and a synchronous load enable.
module registro_pc
    import secuenciador_pkg::*;
#(
    parameter int               ANCHO       = ANCHO_DEF,
    parameter logic [ANCHO-1:0] VALOR_RESET = {ANCHO{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carga,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    // Hold the PC; load a new value only when the sequencer asks for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= VALOR_RESET;
        end else if (carga) begin
            q <= d;
        end
    end

endmodule

// File: rtl/secuenciador_pc.sv
// secuenciador_pc: fetch-address controller owning the PC of the 64-bit core.
// Chooses the next fetch address (PC+4, branch target, exception vector or
// hold), runs the im_req/im_ack handshake and reports completed fetches.
// Optional feature macro: SECUENCIADOR_EXCEPCION_EN enables the exception
// path (VECTOR_EXC, pc_epc, exception kind in the pending register). Without
// it the excepcion input is ignored and pc_epc reads as zero.
module secuenciador_pc
    import secuenciador_pkg::*;
#(
    parameter int               ANCHO        = ANCHO_DEF,
    parameter logic [ANCHO-1:0] VECTOR_RESET = {ANCHO{1'b0}},
    parameter logic [ANCHO-1:0] VECTOR_EXC   = ANCHO'(64'h180)
) (
    input  logic               clk,
    input  logic               rst,
    secuenciador_pc_if.master  bus
);

    estado_t          estado_r;
    estado_t          estado_sig_s;
    pendiente_t       pend_tipo_r;
    logic [ANCHO-1:0] pend_dir_r;
    logic [ANCHO-1:0] pc_s;
    logic [ANCHO-1:0] pc_sig_s;
    logic [ANCHO-1:0] destino_s;
    logic             carga_pc_s;
    logic             tomar_epc_s;
    logic             exc_s;
    logic             buscado_valido_r;
    logic [ANCHO-1:0] pc_buscado_r;

`ifdef SECUENCIADOR_EXCEPCION_EN
    logic [ANCHO-1:0] pc_epc_r;
    assign exc_s = bus.excepcion;
`else
    logic unused_excepcion;
    assign exc_s            = 1'b0;
    assign unused_excepcion = ^{bus.excepcion, tomar_epc_s};
`endif

    // Branch targets are word aligned: the two low bits are dropped.
    assign destino_s = bus.direccion_salto & {{(ANCHO-2){1'b1}}, 2'b00};

    registro_pc #(
        .ANCHO       (ANCHO),
        .VALOR_RESET (VECTOR_RESET)
    ) u_registro_pc (
        .clk   (clk),
        .rst   (rst),
        .carga (carga_pc_s),
        .d     (pc_sig_s),
        .q     (pc_s)
    );

    // Next-state and next-PC selection with redirect priority.
    always_comb begin
        estado_sig_s = estado_r;
        pc_sig_s     = pc_s;
        carga_pc_s   = 1'b0;
        tomar_epc_s  = 1'b0;
        case (estado_r)
            INICIO: begin
                estado_sig_s = BUSCAR;
            end
            BUSCAR: begin
                if (bus.im_ack) begin
                    carga_pc_s = 1'b1;
                    if (exc_s || (pend_tipo_r == EXC)) begin
                        pc_sig_s    = VECTOR_EXC;
                        tomar_epc_s = 1'b1;
                    end else if (bus.salto_tomado) begin
                        pc_sig_s = destino_s;
                    end else if (pend_tipo_r == SALTO) begin
                        pc_sig_s = pend_dir_r;
                    end else begin
                        pc_sig_s = pc_s + ANCHO'(INCREMENTO);
                    end
                    estado_sig_s = bus.detener ? DETENIDO : BUSCAR;
                end else begin
                    estado_sig_s = BUSCAR;
                end
            end
            DETENIDO: begin
                if (exc_s) begin
                    carga_pc_s  = 1'b1;
                    pc_sig_s    = VECTOR_EXC;
                    tomar_epc_s = 1'b1;
                end else if (bus.salto_tomado) begin
                    carga_pc_s = 1'b1;
                    pc_sig_s   = destino_s;
                end else begin
                    carga_pc_s = 1'b0;
                end
                estado_sig_s = bus.detener ? DETENIDO : BUSCAR;
            end
            default: begin
                estado_sig_s = INICIO;
            end
        endcase
    end

    // FSM state register; reset drops the outstanding request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r <= INICIO;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Latch redirects seen while a request waits for its ack; an exception
    // is sticky, a later branch replaces an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_tipo_r <= NINGUNO;
            pend_dir_r  <= {ANCHO{1'b0}};
        end else if ((estado_r == BUSCAR) && !bus.im_ack) begin
            if (exc_s) begin
                pend_tipo_r <= EXC;
            end else if (bus.salto_tomado && (pend_tipo_r != EXC)) begin
                pend_tipo_r <= SALTO;
                pend_dir_r  <= destino_s;
            end
        end else begin
            pend_tipo_r <= NINGUNO;
        end
    end

    // Report each completed fetch to IF/ID one cycle after its ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buscado_valido_r <= 1'b0;
            pc_buscado_r     <= {ANCHO{1'b0}};
        end else if ((estado_r == BUSCAR) && bus.im_ack) begin
            buscado_valido_r <= 1'b1;
            pc_buscado_r     <= pc_s;
        end else begin
            buscado_valido_r <= 1'b0;
        end
    end

`ifdef SECUENCIADOR_EXCEPCION_EN
    // Save the PC that was current when an exception took effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_epc_r <= {ANCHO{1'b0}};
        end else if (tomar_epc_s) begin
            pc_epc_r <= pc_s;
        end
    end

    assign bus.pc_epc = pc_epc_r;
`else
    assign bus.pc_epc = {ANCHO{1'b0}};
`endif

    assign bus.im_req         = (estado_r == BUSCAR);
    assign bus.direccion_im   = pc_s;
    assign bus.buscado_valido = buscado_valido_r;
    assign bus.pc_buscado     = pc_buscado_r;

endmodule

// File: tb/tb_secuenciador_pc.sv
// Testbench for secuenciador_pc: directed scenarios plus random traffic,
// compared against a behavioural reference model. Completed fetches go
// through a scoreboard queue checked by an independent monitor process.
module tb_secuenciador_pc;

    localparam logic [63:0] VR = 64'h0;
    localparam logic [63:0] VE = 64'h180;

    logic clk;
    logic rst;

    secuenciador_pc_if #(.ANCHO(64)) bus ();

    secuenciador_pc #(
        .ANCHO        (64),
        .VECTOR_RESET (VR),
        .VECTOR_EXC   (VE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errores = 0;
    int checks  = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_epc;
    logic [63:0] m_pend_dir;
    bit          m_ini;
    bit          m_req;
    bit          m_pend_exc;
    bit          m_pend_salto;
    logic [63:0] esperados[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] esp);
        checks++;
        if (act !== esp) begin
            errores++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nombre, act, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_pc         = VR;
        m_epc        = 64'h0;
        m_pend_dir   = 64'h0;
        m_ini        = 1'b1;
        m_req        = 1'b0;
        m_pend_exc   = 1'b0;
        m_pend_salto = 1'b0;
        esperados.delete();
    endtask

    // One clock edge of the specified behaviour, given the inputs present at it.
    task automatic modelo_paso(input bit ack, input bit det, input bit salto,
                               input logic [63:0] dir, input bit exc_in);
        bit          e;
        logic [63:0] destino;
`ifdef SECUENCIADOR_EXCEPCION_EN
        e = exc_in;
`else
        e = 1'b0;
`endif
        destino = {dir[63:2], 2'b00};
        if (m_ini) begin
            m_ini = 1'b0;
            m_req = 1'b1;
        end else if (m_req) begin
            if (ack) begin
                esperados.push_back(m_pc);
                if (e || m_pend_exc) begin
                    m_epc = m_pc;
                    m_pc  = VE;
                end else if (salto) begin
                    m_pc = destino;
                end else if (m_pend_salto) begin
                    m_pc = m_pend_dir;
                end else begin
                    m_pc = m_pc + 64'd4;
                end
                m_pend_exc   = 1'b0;
                m_pend_salto = 1'b0;
                m_req        = !det;
            end else if (e) begin
                m_pend_exc = 1'b1;
            end else if (salto && !m_pend_exc) begin
                m_pend_salto = 1'b1;
                m_pend_dir   = destino;
            end
        end else begin
            if (e) begin
                m_epc = m_pc;
                m_pc  = VE;
            end else if (salto) begin
                m_pc = destino;
            end
            m_req = !det;
        end
    endtask

    task automatic comprobar();
        chk("im_req", {63'h0, bus.im_req}, {63'h0, m_req});
        chk("direccion_im", bus.direccion_im, m_pc);
        chk("pc_epc", bus.pc_epc, m_epc);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic ciclo(input bit ack, input bit det, input bit salto,
                         input logic [63:0] dir, input bit exc_in);
        bus.im_ack          = ack;
        bus.detener         = det;
        bus.salto_tomado    = salto;
        bus.direccion_salto = dir;
        bus.excepcion       = exc_in;
        @(posedge clk);
        modelo_paso(ack, det, salto, dir, exc_in);
        @(negedge clk);
        comprobar();
    endtask

    // Scoreboard monitor: every completed-fetch pulse must match the oldest expected address.
    always @(negedge clk) begin
        logic [63:0] esp;
        if (!rst) begin
            checks++;
            if (bus.buscado_valido) begin
                if (esperados.size() == 0) begin
                    errores++;
                    $display("FAIL buscado_extra: got pulse pc=%h expected no pulse", bus.pc_buscado);
                end else begin
                    esp = esperados.pop_front();
                    if (bus.pc_buscado !== esp) begin
                        errores++;
                        $display("FAIL pc_buscado: got %h expected %h", bus.pc_buscado, esp);
                    end
                end
            end else if (esperados.size() != 0) begin
                errores++;
                $display("FAIL buscado_falta: got no pulse expected pc=%h", esperados[0]);
                void'(esperados.pop_front());
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.im_ack          = 1'b0;
        bus.detener         = 1'b0;
        bus.salto_tomado    = 1'b0;
        bus.direccion_salto = 64'h0;
        bus.excepcion       = 1'b0;
        modelo_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valido", {63'h0, bus.buscado_valido}, 64'h0);
        chk("reset_pc_buscado", bus.pc_buscado, 64'h0);
        comprobar();
        rst = 1'b0;

        // Sequential fetch with im_ack held high
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("seq0", bus.direccion_im, 64'h0);
        for (int i = 1; i < 4; i++) begin
            ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
            chk("seq", bus.direccion_im, 64'(i * 4));
        end

        // Branch in the ack cycle, unaligned target
        ciclo(1'b1, 1'b0, 1'b1, 64'h1003, 1'b0);
        chk("salto_ack", bus.direccion_im, 64'h1000);

        // Branch while waiting for ack
        ciclo(1'b0, 1'b0, 1'b1, 64'h200, 1'b0);
        chk("espera0", bus.direccion_im, 64'h1000);
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("espera2", bus.direccion_im, 64'h1000);
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("salto_pend", bus.direccion_im, 64'h200);

        // Exception pending, later branch must not overwrite it
        ciclo(1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        ciclo(1'b0, 1'b0, 1'b1, 64'h80, 1'b0);
        chk("exc_espera", bus.direccion_im, 64'h40);
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
`ifdef SECUENCIADOR_EXCEPCION_EN
        chk("exc_vector", bus.direccion_im, 64'h180);
        chk("exc_epc", bus.pc_epc, 64'h40);
`else
        chk("exc_ignorada", bus.direccion_im, 64'h80);
        chk("epc_cero", bus.pc_epc, 64'h0);
`endif

        // Stall after ack at 0x10
        ciclo(1'b1, 1'b0, 1'b1, 64'h10, 1'b0);
        ciclo(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        chk("det_req0", {63'h0, bus.im_req}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            ciclo(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
            chk("det_req", {63'h0, bus.im_req}, 64'h0);
        end
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("det_reanuda_req", {63'h0, bus.im_req}, 64'h1);
        chk("det_reanuda_dir", bus.direccion_im, 64'h14);
        ciclo(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        ciclo(1'b0, 1'b1, 1'b1, 64'h300, 1'b0);
        ciclo(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("det_salto", bus.direccion_im, 64'h300);

        // PC+4 wrap at the top of the address space
        ciclo(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("wrap_pre", bus.direccion_im, 64'hFFFF_FFFF_FFFF_FFFC);
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("wrap", bus.direccion_im, 64'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ciclo(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0),
                  {$urandom, $urandom},
                  ($urandom_range(0, 15) == 0));
        end

        // Reset pulsed while a request is outstanding
        ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("pre_rst_req", {63'h0, bus.im_req}, 64'h1);
        bus.im_ack = 1'b1;
        #2;
        rst = 1'b1;
        modelo_reset();
        #1;
        chk("rst_req", {63'h0, bus.im_req}, 64'h0);
        chk("rst_dir", bus.direccion_im, VR);
        chk("rst_valido", {63'h0, bus.buscado_valido}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("restart0", bus.direccion_im, VR);
        ciclo(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("restart1", bus.direccion_im, VR + 64'd4);

        repeat (3) ciclo(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("cola_vacia", 64'(esperados.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
